pkt_arbiter: RTL and testbench
==============================

# pkt_arbiter

Round-robin packet scheduler that shares one `sop`/`vld`/`eop`/`len` packet bus among N requesters. It grants whole packets only, never interleaving beats from different sources, and generates the framing for the winner. It sits upstream of the packet protocol checker, which monitors its output bus unchanged.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `GAP`, default 1: idle cycles forced between the `eop` beat and the next `sop`, 0..3.
- `clk` input, 1 bit: clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req` input, N bits: per-requester packet request, held until granted.
- `req_len` input, 4*N bits: packet length in beats for requester i, at bits [4i+3:4i]; held stable while `req[i]`=1.
- `gnt` output, N bits: one-hot, single-cycle grant pulse.
- `sop` output, 1 bit: first beat of a packet.
- `vld` output, 1 bit: beat valid.
- `eop` output, 1 bit: last beat of a packet.
- `len` output, 4 bits: length of the current packet.
- `sel` output, $clog2(N) bits: index of the current owner.
- `busy` output, 1 bit: high during XFER and GAP.
- `err_zero` output, 1 bit: one-cycle pulse when a request with length 0 was sampled.

## Operation
- All outputs are registered. Reset value of every output is 0. The round-robin pointer resets to 0 and the state resets to IDLE.
- Eligible requester: `req[i]`=1 and `req_len[i]`!=0. A zero-length request is never granted; `err_zero` pulses 1 cycle after each cycle in which such a request is sampled.
- States:
  - IDLE:
    - Arbitrate among eligible requesters.
    - On a winner w, go to XFER.
    - Same edge: `gnt[w]`=1, `sop`=1, `vld`=1, `len`=`req_len[w]`, `sel`=w, `busy`=1.
    - Load the beat counter with `req_len[w]`.
  - XFER:
    - `vld`=1 every cycle.
    - Counter decrements once per beat.
    - `eop`=1 on the beat where remaining=1; `len=1` gives `sop`=`eop`=1 on the same beat.
    - `len` and `sel` hold constant for the whole packet.
    - After `eop`:
      - GAP>0: go to GAP and load the gap counter with GAP.
      - GAP=0: re-arbitrate during the `eop` cycle. A winner's `sop` follows `eop` back-to-back; otherwise go to IDLE.
  - GAP:
    - `vld`/`sop`/`eop` low; `busy`=1.
    - Count down; when the count expires, go to IDLE with the same arbitration as IDLE.
- Round-robin: search starts at the pointer and wraps past N-1 to 0. On a grant to w, the pointer becomes (w+1) mod N.
- Requests are not sampled during XFER (except the `eop` cycle when GAP=0) or during GAP. `req` changes there have no effect.
- A requester that drops `req` before being granted is simply skipped. There is no latching of requests.
- Outside XFER: `len`, `sel`=0; `gnt`=0 except on the grant edge.

## Timing
- Request-to-`sop` latency: 1 cycle (request seen at edge k, `sop` visible after edge k).
- Packet occupies exactly `len` consecutive `vld` cycles.
- Minimum spacing between consecutive `sop`s: `len`+GAP cycles.
- Reset mid-packet (`rst_n`=0 at any edge):
  - All outputs go to 0 after that edge; no `eop` is emitted for the cut packet.
  - Pointer returns to 0.
  - The first grant is possible at the first edge with `rst_n`=1.
- Protocol invariants on the output:
  - `eop` only with `vld`.
  - No `sop` between `sop` and `eop`.
  - No `vld` outside a packet.

## Configuration
- `PKT_ARB_RR_EN` defined: round-robin arbitration as above.
- `PKT_ARB_RR_EN` undefined:
  - Fixed priority; the lowest eligible index always wins.
  - The pointer register is removed.
  - All other behaviour and timing are identical.

## Test plan
- Single request, `req[2]`=1, `req_len[2]`=3, GAP=1 -> 1 cycle later `gnt`=4'b0100 and `sop`/`vld`; 3 `vld` beats with `len`=3, `sel`=2; `eop` on beat 3; 1 idle cycle; `busy` low afterwards.
- All four requesting, lengths 1,2,1,2, GAP=0, `PKT_ARB_RR_EN` -> grant order 0,1,2,3,0; every `sop` immediately follows the previous `eop`; the `len`=1 packets show `sop`=`eop`=1.
- Same stimulus without `PKT_ARB_RR_EN` -> requester 0 granted repeatedly while held; 1..3 never granted.
- `req[1]`=1 with `req_len[1]`=0, plus `req[3]`=1 with `req_len[3]`=2 -> `err_zero` pulses each sampled cycle; only requester 3 is granted.
- `rst_n`=0 on beat 2 of a 5-beat packet -> next cycle all outputs 0 with no `eop`; after release with `req[0]`,`req[1]` high, requester 0 wins (pointer reset).
- `req[1]` toggled during another packet's XFER and dropped before `eop` -> no grant to 1; no glitch on `len`/`sel`.

Source files
------------

// File: rtl/pkt_arbiter.sv
// Packet scheduler: grants whole packets from N requesters onto one sop/vld/eop/len bus.
// Define PKT_ARB_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module pkt_arbiter #(
   parameter int unsigned N   = 4,
   parameter int unsigned GAP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [4*N-1:0]       req_len,
   output logic [N-1:0]         gnt,
   output logic                 sop,
   output logic                 vld,
   output logic                 eop,
   output logic [3:0]           len,
   output logic [$clog2(N)-1:0] sel,
   output logic                 busy,
   output logic                 err_zero
);

   localparam int unsigned SW = $clog2(N);
   localparam int unsigned LW = 4;
   localparam int unsigned GW = 2;

   typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
`ifdef PKT_ARB_RR_EN
   logic [SW-1:0]   ptr_q, ptr_d;
`endif
   logic [N-1:0]    gnt_q, gnt_d;
   logic            sop_q, sop_d;
   logic            vld_q, vld_d;
   logic            eop_q, eop_d;
   logic [LW-1:0]   len_q, len_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            busy_q, busy_d;
   logic            err_zero_q, err_zero_d;

   logic [LW-1:0]   lens [N];
   logic [N-1:0]    elig;
   logic [N-1:0]    zero;
   logic [SW-1:0]   cand;
   logic            win_vld;
   logic [SW-1:0]   win_idx;
   logic [LW-1:0]   win_len;
   logic            arb;

   // Split the length bus and classify each request.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         lens[i] = req_len[LW*i +: LW];
         elig[i] = req[i] && (lens[i] != '0);
         zero[i] = req[i] && (lens[i] == '0);
      end
   end

   // Winner search; round-robin starts at the pointer, fixed priority at index 0.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_len = '0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
`ifdef PKT_ARB_RR_EN
         cand = SW'((32'(ptr_q) + k) % N);
`else
         cand = SW'(k);
`endif
         if (!win_vld && elig[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
            win_len = lens[cand];
         end
      end
   end

   // Next state and registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
`ifdef PKT_ARB_RR_EN
      ptr_d      = ptr_q;
`endif
      gnt_d      = '0;
      sop_d      = 1'b0;
      vld_d      = 1'b0;
      eop_d      = 1'b0;
      len_d      = '0;
      sel_d      = '0;
      busy_d     = 1'b0;
      err_zero_d = 1'b0;
      arb        = 1'b0;

      case (state_q)
         ST_IDLE: arb = 1'b1;
         ST_XFER: begin
            if (cnt_q > LW'(1)) begin
               cnt_d  = cnt_q - LW'(1);
               vld_d  = 1'b1;
               eop_d  = (cnt_q == LW'(2));
               len_d  = len_q;
               sel_d  = sel_q;
               busy_d = 1'b1;
            end else if (GAP != 0) begin
               state_d = ST_GAP;
               gap_d   = GW'(GAP);
               busy_d  = 1'b1;
            end else begin
               arb = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q > GW'(1)) begin
               gap_d  = gap_q - GW'(1);
               busy_d = 1'b1;
            end else begin
               arb = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Arbitration edge: the winner's first beat appears right after it.
      if (arb) begin
         err_zero_d = |zero;
         if (win_vld) begin
            state_d = ST_XFER;
            cnt_d   = win_len;
            gnt_d   = N'(1) << win_idx;
            sop_d   = 1'b1;
            vld_d   = 1'b1;
            eop_d   = (win_len == LW'(1));
            len_d   = win_len;
            sel_d   = win_idx;
            busy_d  = 1'b1;
`ifdef PKT_ARB_RR_EN
            ptr_d   = (win_idx == SW'(N - 1)) ? '0 : win_idx + SW'(1);
`endif
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
`ifdef PKT_ARB_RR_EN
         ptr_q      <= '0;
`endif
         gnt_q      <= '0;
         sop_q      <= 1'b0;
         vld_q      <= 1'b0;
         eop_q      <= 1'b0;
         len_q      <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         err_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
`ifdef PKT_ARB_RR_EN
         ptr_q      <= ptr_d;
`endif
         gnt_q      <= gnt_d;
         sop_q      <= sop_d;
         vld_q      <= vld_d;
         eop_q      <= eop_d;
         len_q      <= len_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         err_zero_q <= err_zero_d;
      end
   end

   assign gnt      = gnt_q;
   assign sop      = sop_q;
   assign vld      = vld_q;
   assign eop      = eop_q;
   assign len      = len_q;
   assign sel      = sel_q;
   assign busy     = busy_q;
   assign err_zero = err_zero_q;

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed bench for pkt_arbiter: GAP=1 instance driven from a vector table,
// GAP=0 instance and mid-packet reset exercised by hand-written sequences.
module tb_pkt_arbiter;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [N-1:0] req_a, req_b;
   logic [15:0]  len_a, len_b;

   logic [N-1:0] a_gnt, b_gnt;
   logic         a_sop, a_vld, a_eop, a_busy, a_err;
   logic         b_sop, b_vld, b_eop, b_busy, b_err;
   logic [3:0]   a_len, b_len;
   logic [1:0]   a_sel, b_sel;

   pkt_arbiter #(.N(4), .GAP(1)) u_gap1 (
      .clk(clk), .rst_n(rst_n), .req(req_a), .req_len(len_a),
      .gnt(a_gnt), .sop(a_sop), .vld(a_vld), .eop(a_eop), .len(a_len),
      .sel(a_sel), .busy(a_busy), .err_zero(a_err)
   );

   pkt_arbiter #(.N(4), .GAP(0)) u_gap0 (
      .clk(clk), .rst_n(rst_n), .req(req_b), .req_len(len_b),
      .gnt(b_gnt), .sop(b_sop), .vld(b_vld), .eop(b_eop), .len(b_len),
      .sel(b_sel), .busy(b_busy), .err_zero(b_err)
   );

   // Output bundle order: gnt, sop, vld, eop, len, sel, busy, err_zero.
   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [15:0] lens;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs [23];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [14:0] ob(input logic [3:0] g, input logic s, input logic v,
                                      input logic e, input logic [3:0] l, input logic [1:0] sl,
                                      input logic b, input logic z);
      return {g, s, v, e, l, sl, b, z};
   endfunction

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                               input logic [14:0] ex);
      vec_t t;
      t.rst_n = r;
      t.req   = rq;
      t.lens  = ln;
      t.exp   = ex;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [14:0] act,
                        input logic [14:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got gnt=%b sop=%b vld=%b eop=%b len=%0d sel=%0d busy=%b err=%b, required gnt=%b sop=%b vld=%b eop=%b len=%0d sel=%0d busy=%b err=%b",
                  name, idx, act[14:11], act[10], act[9], act[8], act[7:4], act[3:2], act[1], act[0],
                  exp[14:11], exp[10], exp[9], exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [14:0] obs_a();
      return {a_gnt, a_sop, a_vld, a_eop, a_len, a_sel, a_busy, a_err};
   endfunction

   function automatic logic [14:0] obs_b();
      return {b_gnt, b_sop, b_vld, b_eop, b_len, b_sel, b_busy, b_err};
   endfunction

   localparam logic [14:0] IDLE_O = 15'h0;
   localparam logic [14:0] GAP_O  = 15'h0002;

   logic [3:0] rr_gnt [7];
   logic       rr_sop [7];
   logic       rr_eop [7];
   logic [3:0] rr_len [7];
   logic [1:0] rr_sel [7];

   initial begin
      rst_n = 1'b0;
      req_a = '0;
      len_a = '0;
      req_b = '0;
      len_b = '0;

      vecs[0]  = mk(1'b0, 4'b0000, 16'h0000, IDLE_O);
      vecs[1]  = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);
      // single request from 2, length 3, then one gap cycle
      vecs[2]  = mk(1'b1, 4'b0100, 16'h0300, ob(4'b0100, 1, 1, 0, 3, 2, 1, 0));
      vecs[3]  = mk(1'b1, 4'b0000, 16'h0000, ob(4'b0000, 0, 1, 0, 3, 2, 1, 0));
      vecs[4]  = mk(1'b1, 4'b0000, 16'h0000, ob(4'b0000, 0, 1, 1, 3, 2, 1, 0));
      vecs[5]  = mk(1'b1, 4'b0000, 16'h0000, GAP_O);
      vecs[6]  = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);
      vecs[7]  = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);
      // zero-length request from 1 alongside a length-2 request from 3
      vecs[8]  = mk(1'b1, 4'b1010, 16'h2000, ob(4'b1000, 1, 1, 0, 2, 3, 1, 1));
      vecs[9]  = mk(1'b1, 4'b0010, 16'h0000, ob(4'b0000, 0, 1, 1, 2, 3, 1, 0));
      vecs[10] = mk(1'b1, 4'b0010, 16'h0000, GAP_O);
      vecs[11] = mk(1'b1, 4'b0010, 16'h0000, ob(4'b0000, 0, 0, 0, 0, 0, 0, 1));
      vecs[12] = mk(1'b1, 4'b0010, 16'h0000, ob(4'b0000, 0, 0, 0, 0, 0, 0, 1));
      vecs[13] = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);
      // single-beat packet
      vecs[14] = mk(1'b1, 4'b0001, 16'h0001, ob(4'b0001, 1, 1, 1, 1, 0, 1, 0));
      vecs[15] = mk(1'b1, 4'b0000, 16'h0000, GAP_O);
      vecs[16] = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);
      // requester 1 toggles during a 4-beat packet and is gone before arbitration
      vecs[17] = mk(1'b1, 4'b0001, 16'h0004, ob(4'b0001, 1, 1, 0, 4, 0, 1, 0));
      vecs[18] = mk(1'b1, 4'b0010, 16'h0030, ob(4'b0000, 0, 1, 0, 4, 0, 1, 0));
      vecs[19] = mk(1'b1, 4'b0000, 16'h0000, ob(4'b0000, 0, 1, 0, 4, 0, 1, 0));
      vecs[20] = mk(1'b1, 4'b0010, 16'h0030, ob(4'b0000, 0, 1, 1, 4, 0, 1, 0));
      vecs[21] = mk(1'b1, 4'b0000, 16'h0000, GAP_O);
      vecs[22] = mk(1'b1, 4'b0000, 16'h0000, IDLE_O);

`ifdef PKT_ARB_RR_EN
      rr_gnt = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
      rr_sop = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      rr_eop = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      rr_len = '{4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd1};
      rr_sel = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
`else
      for (int i = 0; i < 7; i++) begin
         rr_gnt[i] = 4'b0001;
         rr_sop[i] = 1'b1;
         rr_eop[i] = 1'b1;
         rr_len[i] = 4'd1;
         rr_sel[i] = 2'd0;
      end
`endif

      #2;
      for (int i = 0; i < 23; i++) begin
         rst_n = vecs[i].rst_n;
         req_a = vecs[i].req;
         len_a = vecs[i].lens;
         @(posedge clk);
         #1;
         check("vec", i, obs_a(), vecs[i].exp);
      end

      // GAP=0: four requesters, lengths 1,2,1,2, all held
      check("gap0_idle", 0, obs_b(), IDLE_O);
      req_b = 4'b1111;
      len_b = 16'h2121;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         check("gap0_seq", i, obs_b(), ob(rr_gnt[i], rr_sop[i], 1'b1, rr_eop[i], rr_len[i],
                                          rr_sel[i], 1'b1, 1'b0));
      end
      req_b = '0;
      len_b = '0;
      @(posedge clk);
      #1;
      check("gap0_drain", 0, obs_b(), IDLE_O);

      // Reset on beat 2 of a 5-beat packet, then requesters 0 and 1 compete
      req_a = 4'b0001;
      len_a = 16'h0005;
      @(posedge clk);
      #1;
      check("rst_seq", 0, obs_a(), ob(4'b0001, 1, 1, 0, 5, 0, 1, 0));
      req_a = '0;
      len_a = '0;
      @(posedge clk);
      #1;
      check("rst_seq", 1, obs_a(), ob(4'b0000, 0, 1, 0, 5, 0, 1, 0));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_seq", 2, obs_a(), IDLE_O);
      rst_n = 1'b1;
      req_a = 4'b0011;
      len_a = 16'h0025;
      @(posedge clk);
      #1;
      check("rst_seq", 3, obs_a(), ob(4'b0001, 1, 1, 0, 5, 0, 1, 0));
      req_a = 4'b0010;
      @(posedge clk);
      #1;
      check("rst_seq", 4, obs_a(), ob(4'b0000, 0, 1, 0, 5, 0, 1, 0));
      req_a = '0;
      len_a = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_seq", 5, obs_a(), IDLE_O);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_seq", 6, obs_a(), IDLE_O);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
